// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/monitor memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_MON = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: bit 0 = CPU, bit 1 = monitor.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last,
    output req_id_t    o_winner,
    output logic       o_any
);

    // A lone requester wins; on a tie the port not served last wins.
    always_comb begin
        o_any    = |i_req;
        o_winner = REQ_CPU;
        if (i_req == 2'b11) begin
            o_winner = (i_last == REQ_CPU) ? REQ_MON : REQ_CPU;
        end else if (i_req[1]) begin
            o_winner = REQ_MON;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising CPU and monitor accesses onto one
// synchronous-read memory. Memory-side signals are registered; read data
// returns two cycles after the request is sampled.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | sample requests; latch winner's fields into mem_* registers
// ACCESS | memory performs the access; winner's gnt is high
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  mon_req,
    input  logic                  mon_we,
    input  logic [ADDR_WIDTH-1:0] mon_addr,
    input  logic [DATA_WIDTH-1:0] mon_wdata,
    output logic                  mon_gnt,
    output logic                  mon_rvalid,
    output logic [DATA_WIDTH-1:0] mon_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    req_id_t               r_last;
    req_id_t               r_owner;
    req_id_t               w_winner;
    logic                  w_any;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_rvalid;
    logic                  r_mon_rvalid;

    rr_pick2 u_pick (
        .i_req    ({mon_req, cpu_req}),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant decode and winner field mux.
    always_comb begin
        w_state_nxt = r_state;
        cpu_gnt     = 1'b0;
        mon_gnt     = 1'b0;
        w_sel_we    = (w_winner == REQ_CPU) ? cpu_we    : mon_we;
        w_sel_addr  = (w_winner == REQ_CPU) ? cpu_addr  : mon_addr;
        w_sel_wdata = (w_winner == REQ_CPU) ? cpu_wdata : mon_wdata;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                cpu_gnt     = (r_owner == REQ_CPU);
                mon_gnt     = (r_owner == REQ_MON);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side registers, round-robin history and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= REQ_MON;
            r_owner      <= REQ_CPU;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_mon_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_mon_rvalid <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_owner     <= w_winner;
                r_last      <= w_winner;
                r_mem_addr  <= w_sel_addr;
                r_mem_we    <= w_sel_we;
                r_mem_wdata <= w_sel_wdata;
            end else if (r_state == ACCESS) begin
                // Write enable must not outlive the ACCESS cycle.
                r_mem_we     <= 1'b0;
                r_cpu_rvalid <= !r_mem_we && (r_owner == REQ_CPU);
                r_mon_rvalid <= !r_mem_we && (r_owner == REQ_MON);
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign mon_rvalid = r_mon_rvalid;
    assign cpu_rdata  = mem_rdata;
    assign mon_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a synchronous-read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        cpu_req, cpu_we, mon_req, mon_we;
    logic [5:0]  cpu_addr, mon_addr, mem_addr;
    logic [15:0] cpu_wdata, mon_wdata, mem_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, mon_gnt, mon_rvalid, mem_we;
    logic [15:0] cpu_rdata, mon_rdata;

    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];
    logic [15:0] q_cpu [$];
    logic [15:0] q_mon [$];
    logic        q_gid [$];   // expected grant order: 0 = CPU, 1 = MON

    int n_pass = 0;
    int n_chk  = 0;

    mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mon_req    (mon_req),
        .mon_we     (mon_we),
        .mon_addr   (mon_addr),
        .mon_wdata  (mon_wdata),
        .mon_gnt    (mon_gnt),
        .mon_rvalid (mon_rvalid),
        .mon_rdata  (mon_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(int i);
        return (i == 5) ? 16'hBEEF : (16'hA000 | 16'(i));
    endfunction

    // Synchronous-read, read-first memory.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        mon_req = 0; mon_we = 0; mon_addr = '0; mon_wdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_cpu.delete(); q_mon.delete(); q_gid.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({cpu_gnt, mon_gnt, cpu_rvalid, mon_rvalid, mem_we, mem_addr, mem_wdata} !== 27'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {cpu_gnt, mon_gnt, cpu_rvalid, mon_rvalid, mem_we, mem_addr, mem_wdata});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        int t_gnt = -1;
        int t_rv = -1;
        int mon_seen = 0;
        logic [15:0] exp_d;
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h05;
        q_cpu.push_back(ref_mem[5]);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mon_gnt || mon_rvalid) mon_seen++;
            if (cpu_gnt) begin
                if (t_gnt < 0) t_gnt = c;
                cpu_req = 0;
                n_chk++;
                if ({mem_addr, mem_we} !== {6'h05, 1'b0})
                    $display("FAIL cpu_read_mem_side: got addr %h we %b expected addr 05 we 0", mem_addr, mem_we);
                else n_pass++;
            end
            if (cpu_rvalid) begin
                t_rv = c;
                exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                n_chk++;
                if (cpu_rdata !== exp_d) $display("FAIL cpu_read_data: got %h expected %h", cpu_rdata, exp_d);
                else n_pass++;
            end
        end
        n_chk++;
        if (t_gnt !== 1) $display("FAIL cpu_read_gnt_cycle: got %0d expected 1", t_gnt); else n_pass++;
        n_chk++;
        if (t_rv !== 2) $display("FAIL cpu_read_rvalid_cycle: got %0d expected 2", t_rv); else n_pass++;
        n_chk++;
        if (mon_seen !== 0) $display("FAIL cpu_read_mon_quiet: got %0d expected 0", mon_seen); else n_pass++;
        n_chk++;
        if (q_cpu.size() !== 0) $display("FAIL cpu_read_drain: got %0d pending expected 0", q_cpu.size()); else n_pass++;
    endtask

    task automatic test_mon_write_cpu_read();
        int we_cycles = 0;
        int mon_rv = 0;
        int cpu_rv = 0;
        logic [15:0] exp_d;
        mon_req = 1; mon_we = 1; mon_addr = 6'h3F; mon_wdata = 16'h1234;
        ref_mem[63] = 16'h1234;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) we_cycles++;
            if (mon_rvalid) mon_rv++;
            if (mon_gnt) begin
                n_chk++;
                if ({mem_addr, mem_we, mem_wdata} !== {6'h3F, 1'b1, 16'h1234})
                    $display("FAIL mon_write_mem_side: got %h/%b/%h expected 3f/1/1234", mem_addr, mem_we, mem_wdata);
                else n_pass++;
                mon_req = 0; mon_we = 0;
            end
            if (cpu_gnt) cpu_req = 0;
            if (cpu_rvalid) begin
                cpu_rv++;
                exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                n_chk++;
                if (cpu_rdata !== exp_d) $display("FAIL readback_data: got %h expected %h", cpu_rdata, exp_d);
                else n_pass++;
            end
            if (c == 2) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 6'h3F;
                q_cpu.push_back(ref_mem[63]);
            end
        end
        n_chk++;
        if (we_cycles !== 1) $display("FAIL mem_we_pulses: got %0d expected 1", we_cycles); else n_pass++;
        n_chk++;
        if (mon_rv !== 0) $display("FAIL write_no_rvalid: got %0d expected 0", mon_rv); else n_pass++;
        n_chk++;
        if (cpu_rv !== 1) $display("FAIL readback_rvalid_count: got %0d expected 1", cpu_rv); else n_pass++;
    endtask

    task automatic test_tie_after_cpu();
        logic        exp_id;
        logic [15:0] exp_d;
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h01;
        q_cpu.push_back(ref_mem[1]);
        q_gid.push_back(1'b0);
        q_gid.push_back(1'b1);
        q_gid.push_back(1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (cpu_gnt || mon_gnt) begin
                exp_id = (q_gid.size() > 0) ? q_gid.pop_front() : 1'bx;
                n_chk++;
                if ({cpu_gnt, mon_gnt} !== (exp_id ? 2'b01 : 2'b10))
                    $display("FAIL tie_grant_order: got cpu %b mon %b expected id %b", cpu_gnt, mon_gnt, exp_id);
                else n_pass++;
                if (cpu_gnt) cpu_req = 0;
                if (mon_gnt) mon_req = 0;
            end
            if (cpu_rvalid) begin
                exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                n_chk++;
                if (cpu_rdata !== exp_d) $display("FAIL tie_cpu_data: got %h expected %h", cpu_rdata, exp_d);
                else n_pass++;
            end
            if (mon_rvalid) begin
                exp_d = (q_mon.size() > 0) ? q_mon.pop_front() : 16'hxxxx;
                n_chk++;
                if (mon_rdata !== exp_d) $display("FAIL tie_mon_data: got %h expected %h", mon_rdata, exp_d);
                else n_pass++;
            end
            if (c == 2) begin
                cpu_req = 1; cpu_addr = 6'h02; q_cpu.push_back(ref_mem[2]);
                mon_req = 1; mon_we = 0; mon_addr = 6'h03; q_mon.push_back(ref_mem[3]);
            end
        end
        n_chk++;
        if (q_gid.size() + q_cpu.size() + q_mon.size() !== 0)
            $display("FAIL tie_drain: got %0d pending expected 0", q_gid.size() + q_cpu.size() + q_mon.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          last_g = -1;
        int          n_gnt = 0;
        logic        prev_cpu_gnt = 0;
        logic        prev_mon_gnt = 0;
        logic        exp_id;
        logic [15:0] exp_d;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h10;
        mon_req = 1; mon_we = 0; mon_addr = 6'h20;
        for (int k = 0; k < 3; k++) begin
            q_gid.push_back(1'b0); q_gid.push_back(1'b1);
            q_cpu.push_back(ref_mem[16]); q_mon.push_back(ref_mem[32]);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (cpu_rvalid) begin
                exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                n_chk++;
                if (!prev_cpu_gnt || cpu_rdata !== exp_d)
                    $display("FAIL b2b_cpu_rvalid: got data %h prev_gnt %b expected data %h prev_gnt 1",
                             cpu_rdata, prev_cpu_gnt, exp_d);
                else n_pass++;
            end
            if (mon_rvalid) begin
                exp_d = (q_mon.size() > 0) ? q_mon.pop_front() : 16'hxxxx;
                n_chk++;
                if (!prev_mon_gnt || mon_rdata !== exp_d)
                    $display("FAIL b2b_mon_rvalid: got data %h prev_gnt %b expected data %h prev_gnt 1",
                             mon_rdata, prev_mon_gnt, exp_d);
                else n_pass++;
            end
            if (cpu_gnt || mon_gnt) begin
                n_gnt++;
                exp_id = (q_gid.size() > 0) ? q_gid.pop_front() : 1'bx;
                n_chk++;
                if ({cpu_gnt, mon_gnt} !== (exp_id ? 2'b01 : 2'b10) || (c - last_g) !== 2)
                    $display("FAIL b2b_grant: got cpu %b mon %b gap %0d expected id %b gap 2",
                             cpu_gnt, mon_gnt, c - last_g, exp_id);
                else n_pass++;
                last_g = c;
            end
            prev_cpu_gnt = cpu_gnt;
            prev_mon_gnt = mon_gnt;
            if (c == 12) begin
                cpu_req = 0; mon_req = 0;
            end
        end
        n_chk++;
        if (n_gnt !== 6) $display("FAIL b2b_grant_count: got %0d expected 6", n_gnt); else n_pass++;
        n_chk++;
        if (q_cpu.size() + q_mon.size() !== 0)
            $display("FAIL b2b_drain: got %0d pending expected 0", q_cpu.size() + q_mon.size());
        else n_pass++;
    endtask

    task automatic test_rst_in_access();
        int          t_gnt = -1;
        int          n_rv = 0;
        logic [15:0] exp_d;
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h04;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (cpu_gnt !== 1'b1) $display("FAIL rst_pre_gnt: got %b expected 1", cpu_gnt);
                else n_pass++;
                rst = 1'b1; cpu_req = 0;
            end else if (c == 2) begin
                n_chk++;
                if ({cpu_gnt, mon_gnt, cpu_rvalid, mon_rvalid, mem_we, mem_addr, mem_wdata} !== 27'd0)
                    $display("FAIL rst_in_access_outputs: got %h expected 0",
                             {cpu_gnt, mon_gnt, cpu_rvalid, mon_rvalid, mem_we, mem_addr, mem_wdata});
                else n_pass++;
                rst = 1'b0;
                cpu_req = 1; cpu_addr = 6'h07;
                q_cpu.push_back(ref_mem[7]);
            end else begin
                if (cpu_gnt) begin
                    if (t_gnt < 0) t_gnt = c;
                    cpu_req = 0;
                end
                if (cpu_rvalid) begin
                    n_rv++;
                    exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                    n_chk++;
                    if (cpu_rdata !== exp_d) $display("FAIL rst_after_data: got %h expected %h", cpu_rdata, exp_d);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (t_gnt !== 3) $display("FAIL rst_after_gnt_cycle: got %0d expected 3", t_gnt); else n_pass++;
        n_chk++;
        if (n_rv !== 1) $display("FAIL rst_after_rvalid_count: got %0d expected 1", n_rv); else n_pass++;
    endtask

    task automatic test_addr_change();
        int          t_mon_gnt = -1;
        logic [15:0] exp_d;
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h02; q_cpu.push_back(ref_mem[2]);
        mon_req = 1; mon_we = 0; mon_addr = 6'h0A;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                n_chk++;
                if (mem_addr !== 6'h02) $display("FAIL addr_change_cpu_addr: got %h expected 02", mem_addr);
                else n_pass++;
                cpu_req = 0;
            end
            if (mon_gnt) begin
                if (t_mon_gnt < 0) t_mon_gnt = c;
                n_chk++;
                if (mem_addr !== 6'h0C) $display("FAIL addr_change_mon_addr: got %h expected 0c", mem_addr);
                else n_pass++;
                mon_req = 0;
            end
            if (cpu_rvalid) begin
                exp_d = (q_cpu.size() > 0) ? q_cpu.pop_front() : 16'hxxxx;
                n_chk++;
                if (cpu_rdata !== exp_d) $display("FAIL addr_change_cpu_data: got %h expected %h", cpu_rdata, exp_d);
                else n_pass++;
            end
            if (mon_rvalid) begin
                exp_d = (q_mon.size() > 0) ? q_mon.pop_front() : 16'hxxxx;
                n_chk++;
                if (mon_rdata !== exp_d) $display("FAIL addr_change_mon_data: got %h expected %h", mon_rdata, exp_d);
                else n_pass++;
            end
            if (c == 1) mon_addr = 6'h0B;
            if (c == 2) begin
                mon_addr = 6'h0C;
                q_mon.push_back(ref_mem[12]);
            end
        end
        n_chk++;
        if (t_mon_gnt !== 3) $display("FAIL addr_change_mon_gnt_cycle: got %0d expected 3", t_mon_gnt);
        else n_pass++;
        n_chk++;
        if (q_cpu.size() + q_mon.size() !== 0)
            $display("FAIL addr_change_drain: got %0d pending expected 0", q_cpu.size() + q_mon.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        preload = 1'b1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_cpu_read();
        test_mon_write_cpu_read();
        test_tie_after_cpu();
        test_back_to_back();
        test_rst_in_access();
        test_addr_change();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
